// File: rtl/ibex_pkg.sv
// Shared types and constants for the dummy-instruction burst inserter.
package ibex_pkg;

  typedef enum logic {
    COUNT = 1'b0,
    BURST = 1'b1
  } dummy_state_e;

  localparam int unsigned DummyOpW          = 5;
  localparam logic [6:0]  DummyOpcode       = 7'h33;
  localparam logic [6:0]  DummyFunct7Base   = 7'b0000000;
  localparam logic [6:0]  DummyFunct7MulDiv = 7'b0000001;

  localparam int unsigned LfsrWidth = 32;
  localparam int unsigned PermIdxW  = $clog2(LfsrWidth);

  typedef logic [LfsrWidth-1:0][PermIdxW-1:0] lfsr_perm_t;

  // Galois feedback taps for a maximal-length 32-bit sequence.
  localparam logic [LfsrWidth-1:0] LfsrCoeffs             = 32'h8000_0057;
  localparam logic [LfsrWidth-1:0] RndCnstLfsrSeedDefault = 32'h8F3A_5C21;

  // Output bit i is taken from state bit (7*i + 3) mod 32; 7 is odd, so this is a bijection.
  function automatic lfsr_perm_t gen_lfsr_perm();
    lfsr_perm_t perm;
    for (int i = 0; i < LfsrWidth; i++) begin
      perm[i] = PermIdxW'((i * 7 + 3) % 32);
    end
    return perm;
  endfunction

  localparam lfsr_perm_t RndCnstLfsrPermDefault = gen_lfsr_perm();

endpackage

// File: rtl/prim_lfsr.sv
// Galois LFSR with a reseed port, lockup escape and an optionally permuted state output.
module prim_lfsr #(
  parameter int unsigned LfsrDw      = 32,
  parameter int unsigned StateOutDw  = LfsrDw,
  parameter bit          StatePermEn = 1'b0,
  parameter logic [LfsrDw-1:0] DefaultSeed = {{(LfsrDw-1){1'b0}}, 1'b1},
  parameter logic [LfsrDw-1:0] Coeffs      = {1'b1, {(LfsrDw-1){1'b0}}},
  parameter logic [LfsrDw-1:0][$clog2(LfsrDw)-1:0] StatePerm = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  seed_en_i,
  input  logic [LfsrDw-1:0]     seed_i,
  input  logic                  lfsr_en_i,
  output logic [StateOutDw-1:0] state_o
);

  logic [LfsrDw-1:0] lfsr_q, lfsr_d;

  // Reseed has priority over stepping; an all-zero state restarts from the default seed.
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_en_i) begin
      lfsr_d = seed_i;
    end else if (lfsr_en_i) begin
      if (lfsr_q == '0) begin
        lfsr_d = DefaultSeed;
      end else begin
        lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? Coeffs : '0);
      end
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= DefaultSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  if (StatePermEn) begin : g_perm
    for (genvar i = 0; i < StateOutDw; i++) begin : g_bit
      assign state_o[i] = lfsr_q[StatePerm[i]];
    end
  end else begin : g_no_perm
    assign state_o = lfsr_q[StateOutDw-1:0];
  end

endmodule

// File: rtl/ibex_dummy_instr_burst.sv
// Inserts bursts of random dummy ALU instructions between real fetches.
// Define IBEX_DUMMY_INSTR_MULDIV_EN to allow MUL/DIV/REM-class dummies.
module ibex_dummy_instr_burst import ibex_pkg::*; #(
  parameter int unsigned          CntW            = 5,
  parameter int unsigned          BurstW          = 2,
  parameter logic [LfsrWidth-1:0] RndCnstLfsrSeed = RndCnstLfsrSeedDefault,
  parameter lfsr_perm_t           RndCnstLfsrPerm = RndCnstLfsrPermDefault
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              dummy_instr_en_i,
  input  logic [CntW-1:0]   dummy_instr_mask_i,
  input  logic [BurstW-1:0] dummy_burst_mask_i,
  input  logic              dummy_instr_seed_en_i,
  input  logic [31:0]       dummy_instr_seed_i,
  input  logic              fetch_valid_i,
  input  logic              id_in_ready_i,
  output logic              insert_dummy_instr_o,
  output logic [31:0]       dummy_instr_data_o,
  output logic              dummy_burst_active_o
);

  localparam int unsigned LfsrOutW = 2 * DummyOpW + 4 + BurstW + CntW;
  localparam logic [CntW-1:0]   CntOne   = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [BurstW-1:0] BurstOne = {{(BurstW-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic                muldiv;
    logic [2:0]          instr_type;
    logic [DummyOpW-1:0] op_b;
    logic [DummyOpW-1:0] op_a;
    logic [BurstW-1:0]   burst;
    logic [CntW-1:0]     cnt;
  } lfsr_fields_t;

  dummy_state_e      state_q;
  logic [CntW-1:0]   cnt_q;
  logic [CntW-1:0]   thresh;
  logic [BurstW-1:0] rem_q;
  logic [31:0]       seed_q;
  logic [LfsrOutW-1:0] lfsr_state;
  lfsr_fields_t      lfsr_fields;
  logic              lfsr_step;
  logic [6:0]        funct7;

  assign lfsr_fields = lfsr_state;
  assign thresh      = lfsr_fields.cnt & dummy_instr_mask_i;
  assign lfsr_step   = dummy_instr_en_i & (state_q == BURST) & id_in_ready_i;

  prim_lfsr #(
    .LfsrDw      (LfsrWidth),
    .StateOutDw  (LfsrOutW),
    .StatePermEn (1'b1),
    .DefaultSeed (RndCnstLfsrSeed),
    .Coeffs      (LfsrCoeffs),
    .StatePerm   (RndCnstLfsrPerm)
  ) u_lfsr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .seed_en_i (dummy_instr_seed_en_i),
    .seed_i    (seed_q ^ dummy_instr_seed_i),
    .lfsr_en_i (lfsr_step),
    .state_o   (lfsr_state)
  );

  // Accumulated seed history; each strobe folds new seed data in.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seed_q <= '0;
    end else if (dummy_instr_seed_en_i) begin
      seed_q <= seed_q ^ dummy_instr_seed_i;
    end else begin
      seed_q <= seed_q;
    end
  end

  // Count real instructions up to the random threshold, then emit rem_q+1 dummies.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= COUNT;
      cnt_q   <= '0;
      rem_q   <= '0;
    end else if (!dummy_instr_en_i) begin
      state_q <= COUNT;
      cnt_q   <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        COUNT: begin
          if (cnt_q == thresh) begin
            state_q <= BURST;
            rem_q   <= lfsr_fields.burst & dummy_burst_mask_i;
          end else if (fetch_valid_i && id_in_ready_i) begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        BURST: begin
          if (id_in_ready_i) begin
            if (rem_q == '0) begin
              state_q <= COUNT;
              cnt_q   <= '0;
            end else begin
              rem_q <= rem_q - BurstOne;
            end
          end
        end
        default: begin
          state_q <= COUNT;
          cnt_q   <= '0;
          rem_q   <= '0;
        end
      endcase
    end
  end

`ifdef IBEX_DUMMY_INSTR_MULDIV_EN
  assign funct7 = lfsr_fields.muldiv ? DummyFunct7MulDiv : DummyFunct7Base;
`else
  logic unused_muldiv;
  assign unused_muldiv = lfsr_fields.muldiv;
  assign funct7        = DummyFunct7Base;
`endif

  assign insert_dummy_instr_o = dummy_instr_en_i & (state_q == BURST);
  assign dummy_burst_active_o = (state_q == BURST);
  assign dummy_instr_data_o   = {funct7, lfsr_fields.op_b, lfsr_fields.op_a,
                                 lfsr_fields.instr_type, 5'h00, DummyOpcode};

endmodule

// File: tb/tb_ibex_dummy_instr_burst.sv
// Directed self-checking bench for ibex_dummy_instr_burst (default CntW=5, BurstW=2).
module tb_ibex_dummy_instr_burst;

  localparam logic [31:0] SEED_DEF = 32'h8F3A_5C21;
  localparam logic [31:0] POLY     = 32'h8000_0057;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [4:0]  imask;
  logic [1:0]  bmask;
  logic        seed_en;
  logic [31:0] seed_i;
  logic        fv;
  logic        rdy;
  logic        ins;
  logic [31:0] data;
  logic        act;

  int total = 0;
  int bad   = 0;

  logic [31:0] lfsr_m;
  logic [31:0] seed_m;

  always #5 clk = ~clk;

  ibex_dummy_instr_burst dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .dummy_instr_en_i      (en),
    .dummy_instr_mask_i    (imask),
    .dummy_burst_mask_i    (bmask),
    .dummy_instr_seed_en_i (seed_en),
    .dummy_instr_seed_i    (seed_i),
    .fetch_valid_i         (fv),
    .id_in_ready_i         (rdy),
    .insert_dummy_instr_o  (ins),
    .dummy_instr_data_o    (data),
    .dummy_burst_active_o  (act)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    if (s == 32'h0) return SEED_DEF;
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  function automatic logic [31:0] ref_data(input logic [31:0] s);
    logic [20:0] o;
    logic [6:0]  f7;
    for (int i = 0; i < 21; i++) o[i] = s[(i * 7 + 3) % 32];
`ifdef IBEX_DUMMY_INSTR_MULDIV_EN
    f7 = {6'b000000, o[20]};
`else
    f7 = 7'h00;
`endif
    return {f7, o[16:12], o[11:7], o[19:17], 5'h00, 7'h33};
  endfunction

  // Load both the DUT seed register and LFSR with target; takes one clock.
  task automatic reseed(input logic [31:0] target);
    seed_en = 1'b1;
    seed_i  = seed_m ^ target;
    @(negedge clk);
    seed_en = 1'b0;
    seed_i  = 32'h0;
    seed_m  = target;
    lfsr_m  = target;
  endtask

  int fv_vec [5] = '{1, 0, 1, 1, 1};
  int n_ins;

  initial begin
    rst_n = 1'b0; en = 1'b0; imask = 5'h00; bmask = 2'h0;
    seed_en = 1'b0; seed_i = 32'h0; fv = 1'b1; rdy = 1'b1;
    lfsr_m = SEED_DEF; seed_m = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_insert", ins, 1'b0);
    chk("rst_active", act, 1'b0);
    chk("rst_data", data, ref_data(SEED_DEF));
    @(negedge clk);
    rst_n = 1'b1;

    // Zero masks: real and dummy alternate.
    @(negedge clk);
    en = 1'b1;
    #1 chk("alt_first", ins, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("alt_ins", ins, 1'b1);
      chk("alt_data", data, ref_data(lfsr_m));
      lfsr_m = ref_step(lfsr_m);
      @(negedge clk); #1;
      chk("alt_real", ins, 1'b0);
    end

    // Reseed concurrent with an accepted dummy.
    @(negedge clk); #1;
    chk("rs_ins", ins, 1'b1);
    reseed(32'hA5A5_0001);
    #1;
    chk("rs_lfsr", data, ref_data(32'hA5A5_0001));
    chk("rs_state", ins, 1'b0);
    @(negedge clk); #1;
    chk("rs_ins2", ins, 1'b1);
    lfsr_m = ref_step(lfsr_m);
    @(negedge clk); #1;
    chk("rs_step", data, ref_data(lfsr_m));
    reseed(seed_m);
    #1 chk("rs_seedq", data, ref_data(32'hA5A5_0001));

    // Burst of four.
    en = 1'b0; bmask = 2'h3;
    #1 chk("en_off", ins, 1'b0);
    reseed(32'h0000_2040);
    en = 1'b1;
    #1 chk("b4_pre", ins, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("b4_ins", ins, 1'b1);
      chk("b4_act", act, 1'b1);
      chk("b4_data", data, ref_data(lfsr_m));
      lfsr_m = ref_step(lfsr_m);
    end
    @(negedge clk); #1;
    chk("b4_end_ins", ins, 1'b0);
    chk("b4_end_act", act, 1'b0);

    // Stall mid-burst.
    en = 1'b0;
    reseed(32'h0000_2040);
    en = 1'b1;
    @(negedge clk); #1;
    chk("st_ins0", ins, 1'b1);
    rdy = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("st_hold_ins", ins, 1'b1);
      chk("st_hold_data", data, ref_data(lfsr_m));
    end
    rdy = 1'b1;
    lfsr_m = ref_step(lfsr_m);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("st_rest_ins", ins, 1'b1);
      chk("st_rest_data", data, ref_data(lfsr_m));
      lfsr_m = ref_step(lfsr_m);
    end
    @(negedge clk); #1;
    chk("st_end", ins, 1'b0);

    // Enable dropped at second dummy of four.
    en = 1'b0;
    reseed(32'h0000_2040);
    en = 1'b1;
    @(negedge clk); #1;
    chk("ed_first", ins, 1'b1);
    lfsr_m = ref_step(lfsr_m);
    @(negedge clk); #1;
    chk("ed_second", ins, 1'b1);
    en = 1'b0;
    #1 chk("ed_same_cycle", ins, 1'b0);
    @(negedge clk); #1;
    chk("ed_act", act, 1'b0);
    en = 1'b1;
    #1 chk("ed_count", ins, 1'b0);
    @(negedge clk); #1;
    chk("ed_cnt0", act, 1'b1);
    chk("ed_lfsr", data, ref_data(lfsr_m));

    // Threshold 3 with fetch bubbles: count only accepted real instructions.
    en = 1'b0;
    reseed(32'h0000_2448);
    en = 1'b1; imask = 5'h1F; bmask = 2'h0;
    for (int i = 0; i < 5; i++) begin
      fv = fv_vec[i][0];
      #1 chk("th_wait", ins, 1'b0);
      @(negedge clk);
    end
    fv = 1'b1;
    #1;
    chk("th_ins", ins, 1'b1);
    chk("th_data", data, ref_data(lfsr_m));
    lfsr_m = ref_step(lfsr_m);

    // Long run: every dummy checked against the model.
    imask = 5'h00;
    n_ins = 0;
    for (int c = 0; c < 4000 && n_ins < 1000; c++) begin
      @(negedge clk); #1;
      if (ins) begin
        chk("run_data", data, ref_data(lfsr_m));
        lfsr_m = ref_step(lfsr_m);
        n_ins++;
      end
    end
    chk("run_count", n_ins, 1000);

    // Reset in the middle of a burst.
    en = 1'b0; bmask = 2'h3;
    @(negedge clk);
    reseed(32'h0000_2040);
    en = 1'b1;
    @(negedge clk); #1;
    chk("rb_ins", ins, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rb_rst_ins", ins, 1'b0);
    chk("rb_rst_act", act, 1'b0);
    chk("rb_rst_data", data, ref_data(SEED_DEF));
    @(negedge clk); #1;
    chk("rb_held", ins, 1'b0);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibex_dummy_instr_burst.md
IBEX_DUMMY_INSTR_BURST -- requirements
Module: ibex_dummy_instr_burst

Interface
REQ-001 The block SHALL have parameter CntW, default 5, meaning inter-insertion counter width (>=3).
REQ-002 The block SHALL have parameter BurstW, default 2, meaning burst-length field width; max burst = 2^BurstW instructions.
REQ-003 The block SHALL have parameter RndCnstLfsrSeed, default RndCnstLfsrSeedDefault, meaning LFSR reset seed.
REQ-004 The block SHALL have parameter RndCnstLfsrPerm, default RndCnstLfsrPermDefault, meaning LFSR state permutation.
REQ-005 Reset is rst_ni, asynchronous, active-low; clock is clk_i; both SHALL be the first two ports.
REQ-006 The block SHALL have port dummy_instr_en_i, input, 1, meaning insertion enable from CSR.
REQ-007 The block SHALL have port dummy_instr_mask_i, input, CntW, meaning AND-mask on the random threshold.
REQ-008 The block SHALL have port dummy_burst_mask_i, input, BurstW, meaning AND-mask on the random burst field.
REQ-009 The block SHALL have port dummy_instr_seed_en_i, input, 1, meaning reseed strobe.
REQ-010 The block SHALL have port dummy_instr_seed_i, input, 32, meaning seed data.
REQ-011 The block SHALL have port fetch_valid_i, input, 1, meaning a real instruction is offered to ID.
REQ-012 The block SHALL have port id_in_ready_i, input, 1, meaning ID accepts this cycle.
REQ-013 The block SHALL have port insert_dummy_instr_o, output, 1, meaning the IF stage substitutes dummy_instr_data_o.
REQ-014 The block SHALL have port dummy_instr_data_o, output, 32, meaning dummy instruction encoding.
REQ-015 The block SHALL have port dummy_burst_active_o, output, 1, meaning FSM is in BURST.

Function
REQ-016 FSM states SHALL be COUNT and BURST; insert_dummy_instr_o = dummy_instr_en_i & (state==BURST).
REQ-017 In COUNT: cnt_q SHALL increment (mod 2^CntW) on every cycle with en & fetch_valid_i & id_in_ready_i.
REQ-018 Threshold SHALL equal lfsr.cnt & dummy_instr_mask_i; when en and cnt_q==threshold in COUNT, next state SHALL be BURST with rem_q = (lfsr.burst & dummy_burst_mask_i); no increment that cycle.
REQ-019 In BURST: each cycle with id_in_ready_i SHALL accept one dummy, step the LFSR once; if rem_q==0 return to COUNT with cnt_q=0, else rem_q decrements.
REQ-020 Burst length SHALL be rem_q+1, range 1..2^BurstW; all-zero masks give exactly one dummy per accepted real instruction.
REQ-021 id_in_ready_i low in BURST SHALL hold state, rem_q, LFSR, and dummy_instr_data_o stable.
REQ-022 dummy_instr_en_i deasserted in any state SHALL force insert_dummy_instr_o low same cycle and next state COUNT with cnt_q=0, rem_q=0.
REQ-023 Seed register SHALL update seed_q <= seed_q ^ dummy_instr_seed_i on seed_en; LFSR SHALL load seed_q ^ seed_i; reseed wins over a simultaneous LFSR step; FSM unaffected.
REQ-024 dummy_instr_data_o SHALL be {funct7, op_b, op_a, instr_type, 5'h00, 7'h33}; rd always x0; funct7 = 7'b0000000 unless REQ-029 applies.
REQ-025 LFSR output fields SHALL be, MSB to LSB: muldiv(1), instr_type(3), op_b(5), op_a(5), burst(BurstW), cnt(CntW).

Reset
REQ-026 On reset: state=COUNT, cnt_q=0, rem_q=0, seed_q=0, LFSR=RndCnstLfsrSeed.
REQ-027 On reset: insert_dummy_instr_o=0, dummy_burst_active_o=0; dummy_instr_data_o reflects the seed-derived LFSR state.
REQ-028 Reset asserted mid-burst SHALL abort the burst with no further insertion.

Configuration
REQ-029 With IBEX_DUMMY_INSTR_MULDIV_EN defined, funct7 SHALL be 7'b0000001 when lfsr.muldiv==1 (MUL/DIV/REM class); without it, funct7 SHALL always be 7'b0000000 and the muldiv bit is ignored.

Structure
REQ-030 ibex_pkg SHALL hold dummy_state_e (COUNT, BURST), DummyOpW=5, DummyOpcode=7'h33 and funct7 constants; parametric field struct stays local.
REQ-031 The single sub-module SHALL be prim_lfsr (LfsrDw=LfsrWidth, StatePermEn=1, StateOutDw = 14+BurstW+CntW).

Verification
REQ-032 Mask=0, burst mask=0, en=1, fetch_valid/ready=1 -> dummy on every second accepted cycle, burst of 1.
REQ-033 Force lfsr.burst=3, burst mask=3'h3 (BurstW=2) -> exactly 4 consecutive inserts, then cnt_q=0 in COUNT.
REQ-034 ready low 3 cycles mid-burst -> insert held high, data unchanged, rem_q unchanged.
REQ-035 en dropped at 2nd of 4 burst instrs -> insert low same cycle, state COUNT next cycle, cnt_q=0.
REQ-036 seed_en with seed_i=32'hA5A5_0001 concurrent with accepted dummy -> LFSR equals reseed value, seed_q=32'hA5A5_0001.
REQ-037 With and without IBEX_DUMMY_INSTR_MULDIV_EN, 1000 inserts -> funct7 only 0x00/0x01 resp. 0x00; rd=0, opcode 0x33 always.
